// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for pipeline control
//
// Purpose: flush FSM state encoding, stall/no-stall constants and the
//          thermometer-mask helper shared by pipe_ctrl and the pipeline
//          register modules.
// Contents:
//   state_e      - flush FSM states (IDLE, FLUSH)
//   Stop/NoStop  - values of one stall bit
//   MAX_STAGES   - widest stall vector the mask helper supports
//   thermo_mask  - bits idx..MAX_STAGES-1 set, lower bits clear
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int MAX_STAGES = 32;

  // Stage idx stalls itself and every boundary upstream of it (higher
  // indices), so the mask covers idx and everything above.
  function automatic logic [MAX_STAGES-1:0] thermo_mask(input int idx);
    logic [MAX_STAGES-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_STAGES; k++) begin
      if (k >= idx) m[k] = Stop;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_mask_enc.sv
// rtl/pipe_ctrl_stall_mask_enc.sv - stall request to stall/bubble vector encoder
//
// Purpose: combinational merge of per-stage stall requests. The lowest
//          requesting stage r stalls boundaries r..STAGES-1 and a bubble is
//          inserted into register r-1 so downstream stages drain.
// Ports:
//   req    in  [STAGES-1:0] per-stage stall requests
//   stall  out [STAGES-1:0] thermometer hold vector
//   bubble out [STAGES-1:0] one-hot NOP insert vector (zero when r = 0)
module stall_mask_enc
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 6
) (
  input  logic [STAGES-1:0] req,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble
);

  logic found;
  int   idx;

  always_comb begin
    found  = 1'b0;
    idx    = 0;
    stall  = '0;
    bubble = '0;
    // Scan downward so the last hit is the lowest requesting stage.
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
    if (found) begin
      stall = STAGES'(thermo_mask(idx));
      for (int k = 0; k < STAGES; k++) begin
        if (k + 1 == idx) bubble[k] = Stop;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush control unit
//
// Purpose: merges stall requests into stall/bubble vectors, sequences
//          flushes with a latched redirect PC, counts stalled PC cycles
//          and runs a sticky stall watchdog.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   stallreq_i   in   [STAGES-1:0] per-stage stall requests
//   flush_req_i  in   flush request
//   flush_pc_i   in   [PC_W-1:0] redirect target, sampled with flush_req_i
//   stall_o      out  [STAGES-1:0] hold vector (combinational)
//   bubble_o     out  [STAGES-1:0] NOP insert vector (combinational)
//   flush_o      out  clear all pipeline registers (registered)
//   new_pc_o     out  [PC_W-1:0] PC load value while flush_o (registered)
//   stall_cnt_o  out  [CNT_W-1:0] saturating count of PC-stall cycles
//   timeout_o    out  sticky watchdog flag
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES  = 6,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic              flush_req_i,
  input  logic [PC_W-1:0]   flush_pc_i,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] bubble_o,
  output logic              flush_o,
  output logic [PC_W-1:0]   new_pc_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              timeout_o
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);

  state_e            state;
  logic [STAGES-1:0] enc_stall;
  logic [STAGES-1:0] enc_bubble;
  logic [RUN_W-1:0]  run_cnt;
  logic              stall_any;

  stall_mask_enc #(
    .STAGES (STAGES)
  ) u_enc (
    .req    (stallreq_i),
    .stall  (enc_stall),
    .bubble (enc_bubble)
  );

  // A flush clears every register anyway, so holding or bubbling would
  // only fight it; reset likewise suppresses all stall activity.
  always_comb begin
    stall_o  = '0;
    bubble_o = '0;
    if (!rst && !flush_o) begin
      stall_o  = enc_stall;
      bubble_o = enc_bubble;
    end
  end

  assign stall_any = |stall_o;

  // Flush FSM. Both states reload the PC on a request so back-to-back
  // redirects each carry their own target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      flush_o  <= 1'b0;
      new_pc_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req_i) begin
            state    <= FLUSH;
            flush_o  <= 1'b1;
            new_pc_o <= flush_pc_i;
          end
        end
        FLUSH: begin
          if (flush_req_i) begin
            state    <= FLUSH;
            flush_o  <= 1'b1;
            new_pc_o <= flush_pc_i;
          end else begin
            state   <= IDLE;
            flush_o <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

  // Cycles in which the PC register is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (stall_o[STAGES-1] && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  // Watchdog: the flag registers on the edge that closes the TIMEOUT-th
  // consecutive stalled cycle, i.e. when the run counter reaches TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt   <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (stall_any) begin
        if (run_cnt != RUN_W'(TIMEOUT)) run_cnt <= run_cnt + RUN_W'(1);
        if (run_cnt >= RUN_W'(TIMEOUT - 1)) timeout_o <= 1'b1;
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule
